rvh_mmu_ptw: RTL and testbench
==============================

Name: rvh_mmu_ptw

Overview:
Sv39 hardware page-table walker directly downstream of the MMU miss-status buffer. It accepts one granted TLB-miss request at a time (trans_id, asid, vpn, access_type) and walks up to three page-table levels through a single-outstanding memory port. It returns the leaf PTE, or a page/access fault, tagged with the original trans_id. The trans_id return releases the miss-buffer entry.

Parameters:
VPN_WIDTH, 27, virtual page number width (3 x 9-bit indices)
PPN_WIDTH, 44, physical page number width
PADDR_WIDTH, 56, physical address width of memory requests
TRANS_ID_WIDTH, 3, miss transaction tag width
ASID_WIDTH, 16, address-space id width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
satp_ppn_i  in  PPN_WIDTH  root page-table PPN, sampled on request accept
ptw_req_vld_i  in  1  miss request valid
ptw_req_rdy_o  out  1  walker idle, can accept
ptw_req_trans_id_i  in  TRANS_ID_WIDTH  request tag
ptw_req_asid_i  in  ASID_WIDTH  request ASID
ptw_req_vpn_i  in  VPN_WIDTH  request VPN
ptw_req_access_type_i  in  2  access type, passed through
mem_req_vld_o  out  1  PTE read request valid
mem_req_paddr_o  out  PADDR_WIDTH  PTE physical address
mem_req_rdy_i  in  1  memory accepts request
mem_resp_vld_i  in  1  PTE read data valid
mem_resp_pte_i  in  64  PTE read data
mem_resp_err_i  in  1  bus error on the read
ptw_resp_vld_o  out  1  walk result, one-cycle pulse, no backpressure
ptw_resp_trans_id_o  out  TRANS_ID_WIDTH  tag of the completed walk
ptw_resp_asid_o / ptw_resp_vpn_o / ptw_resp_access_type_o  out  ASID_WIDTH / VPN_WIDTH / 2  echoed request fields
ptw_resp_pte_o  out  64  leaf PTE; zero on fault
ptw_resp_level_o  out  2  level of the leaf or fault (2 = 1 GiB, 1 = 2 MiB, 0 = 4 KiB)
ptw_resp_page_fault_o  out  1  page fault
ptw_resp_access_fault_o  out  1  access fault (bus error)

Behaviour:
- Reset: state IDLE, level=2, ptw_req_rdy_o=1, mem_req_vld_o=0, ptw_resp_vld_o=0, all data outputs 0. Reset mid-walk abandons the walk with no response.
- FSM states:
  - IDLE: rdy=1. On vld&rdy, latch trans_id/asid/vpn/access_type, a_ppn=satp_ppn_i, level=2, go to REQ.
  - REQ: mem_req_vld_o=1, paddr = zero-extend({a_ppn, vpn[9*level+8 : 9*level], 3'b000}) truncated to PADDR_WIDTH. Hold valid and a stable address until mem_req_rdy_i, then go to WAIT.
  - WAIT: on mem_resp_vld_i, evaluate the PTE:
    - err=1 -> access fault.
    - V=0, or R=0&W=1 -> page fault.
    - R|X leaf: level>0 with nonzero PPN bits below the level (ppn[8:0] for level 1, ppn[17:0] for level 2) -> page fault (misaligned superpage); otherwise success.
    - Non-leaf at level 0 -> page fault.
    - Otherwise a_ppn=pte[53:10], level-=1, go to REQ.
    Success or fault -> latch the result and go to RESP.
  - RESP: ptw_resp_vld_o=1 for exactly one cycle with the latched fields, then return to IDLE.
- mem_resp_vld_i outside WAIT is ignored. Exactly one memory request is outstanding at any time.
- A/D and permission checks are not done here; the TLB does them from the returned PTE.
- Latency with a zero-wait memory (rdy=1, response one cycle after the request):
  - Request accepted at T: first mem_req at T+1.
  - Level-2 leaf: response at T+3.
  - Full 3-level walk: response at T+7.
- ptw_req_rdy_o is high only in IDLE. The next request can be accepted the cycle after RESP.

Decomposition:
- rvh_mmu_pkg holds: PTE bit positions (V, R, W, X, U, G, A, D, PPN[53:10]), PT_LEVELS=3, VPN_IDX_WIDTH=9, PTE_SIZE_LOG2=3, the FSM state enum.
- One combinational sub-module, rvh_mmu_ptw_pte_check. Inputs: pte, level, err. Outputs: is_leaf, page_fault, access_fault, next_ppn.
- The FSM, latches and address generation stay in rvh_mmu_ptw.

Test Plan:
- 3-level walk: satp_ppn=0x80000, vpn=0x0040201, zero-wait memory.
  - mem addresses 0x80000008, 0x80001008, 0x80002008.
  - PTEs returned: 0x20000401, 0x20000801, 0x48D14CF.
  - Expect resp at T+7: pte=0x48D14CF, level=0, both faults 0, trans_id echoed.
- Level-1 leaf with PTE 0x480004CF (ppn 0x120001): misaligned superpage -> page_fault=1, level=1, pte=0, only 2 memory requests.
- Level-2 PTE 0x0 (V=0) -> page_fault=1, level=2 at T+3. Repeat with mem_resp_err_i=1 -> access_fault=1, page_fault=0.
- mem_req_rdy_i held low 5 cycles -> mem_req_vld_o and paddr stable throughout; ptw_req_rdy_o=0; a second ptw_req_vld_i is not accepted.
- Spurious mem_resp_vld_i in IDLE or REQ -> no state change, no response. Then assert rstn=0 in WAIT -> all outputs return to reset values immediately and no response is issued after reset.

Source files
------------

// File: rtl/rvh_mmu_pkg.sv
// Shared definitions for the Sv39 page-table walker: PTE layout, walk geometry, FSM states.
package rvh_mmu_pkg;

  // Sv39 walk geometry
  localparam int PT_LEVELS     = 3;
  localparam int VPN_IDX_WIDTH = 9;
  localparam int PTE_SIZE_LOG2 = 3;

  // PTE bit positions
  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;
  localparam int PTE_PPN_W   = PTE_PPN_MSB - PTE_PPN_LSB + 1;

  typedef enum logic [1:0] {
    PTW_IDLE = 2'd0,
    PTW_REQ  = 2'd1,
    PTW_WAIT = 2'd2,
    PTW_RESP = 2'd3
  } ptw_state_e;

endpackage

// File: rtl/rvh_mmu_ptw_pte_check.sv
// Classifies one PTE read: leaf vs. pointer, page/access fault, and the next-level PPN.
module rvh_mmu_ptw_pte_check
  import rvh_mmu_pkg::*;
(
  input  logic [63:0]          pte_i,
  input  logic [1:0]           level_i,
  input  logic                 err_i,
  output logic                 is_leaf_o,
  output logic                 page_fault_o,
  output logic                 access_fault_o,
  output logic [PTE_PPN_W-1:0] next_ppn_o
);

  logic pte_v, pte_r, pte_w, pte_x;
  logic misaligned;

  assign pte_v      = pte_i[PTE_V];
  assign pte_r      = pte_i[PTE_R];
  assign pte_w      = pte_i[PTE_W];
  assign pte_x      = pte_i[PTE_X];
  assign next_ppn_o = pte_i[PTE_PPN_MSB:PTE_PPN_LSB];

  // Superpage leaves must have the PPN bits covered by the page offset cleared
  always_comb begin
    misaligned = 1'b0;
    case (level_i)
      2'd1:    misaligned = |pte_i[PTE_PPN_LSB +: VPN_IDX_WIDTH];
      2'd2:    misaligned = |pte_i[PTE_PPN_LSB +: 2*VPN_IDX_WIDTH];
      default: misaligned = 1'b0;
    endcase
  end

  // Fault classification; a bus error overrides anything decoded from the data
  always_comb begin
    is_leaf_o      = pte_r | pte_x;
    access_fault_o = err_i;
    page_fault_o   = ~err_i & ( ~pte_v
                              | (~pte_r & pte_w)
                              | ((pte_r | pte_x) & misaligned)
                              | (~(pte_r | pte_x) & (level_i == 2'd0)));
  end

endmodule

// File: rtl/rvh_mmu_ptw.sv
// Sv39 page-table walker: one miss at a time, single outstanding PTE read, leaf/fault returned by tag.
module rvh_mmu_ptw
  import rvh_mmu_pkg::*;
#(
  parameter int VPN_WIDTH      = 27,
  parameter int PPN_WIDTH      = 44,
  parameter int PADDR_WIDTH    = 56,
  parameter int TRANS_ID_WIDTH = 3,
  parameter int ASID_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PPN_WIDTH-1:0]      satp_ppn_i,
  input  logic                      ptw_req_vld_i,
  output logic                      ptw_req_rdy_o,
  input  logic [TRANS_ID_WIDTH-1:0] ptw_req_trans_id_i,
  input  logic [ASID_WIDTH-1:0]     ptw_req_asid_i,
  input  logic [VPN_WIDTH-1:0]      ptw_req_vpn_i,
  input  logic [1:0]                ptw_req_access_type_i,
  output logic                      mem_req_vld_o,
  output logic [PADDR_WIDTH-1:0]    mem_req_paddr_o,
  input  logic                      mem_req_rdy_i,
  input  logic                      mem_resp_vld_i,
  input  logic [63:0]               mem_resp_pte_i,
  input  logic                      mem_resp_err_i,
  output logic                      ptw_resp_vld_o,
  output logic [TRANS_ID_WIDTH-1:0] ptw_resp_trans_id_o,
  output logic [ASID_WIDTH-1:0]     ptw_resp_asid_o,
  output logic [VPN_WIDTH-1:0]      ptw_resp_vpn_o,
  output logic [1:0]                ptw_resp_access_type_o,
  output logic [63:0]               ptw_resp_pte_o,
  output logic [1:0]                ptw_resp_level_o,
  output logic                      ptw_resp_page_fault_o,
  output logic                      ptw_resp_access_fault_o
);

  localparam int FULL_ADDR_W = PPN_WIDTH + VPN_IDX_WIDTH + PTE_SIZE_LOG2;

  ptw_state_e                state_q, state_d;
  logic [1:0]                level_q, level_d;
  logic [PPN_WIDTH-1:0]      a_ppn_q, a_ppn_d;
  logic [TRANS_ID_WIDTH-1:0] trans_id_q, trans_id_d;
  logic [ASID_WIDTH-1:0]     asid_q, asid_d;
  logic [VPN_WIDTH-1:0]      vpn_q, vpn_d;
  logic [1:0]                acc_q, acc_d;
  logic [63:0]               pte_q, pte_d;
  logic [1:0]                res_level_q, res_level_d;
  logic                      pf_q, pf_d;
  logic                      af_q, af_d;

  logic                      chk_leaf, chk_pf, chk_af;
  logic [PTE_PPN_W-1:0]      chk_next_ppn;
  logic [VPN_IDX_WIDTH-1:0]  vpn_idx;
  logic [FULL_ADDR_W-1:0]    addr_full;

  rvh_mmu_ptw_pte_check u_pte_check (
    .pte_i          (mem_resp_pte_i),
    .level_i        (level_q),
    .err_i          (mem_resp_err_i),
    .is_leaf_o      (chk_leaf),
    .page_fault_o   (chk_pf),
    .access_fault_o (chk_af),
    .next_ppn_o     (chk_next_ppn)
  );

  // VPN slice indexing the table at the current level
  always_comb begin
    vpn_idx = vpn_q[0 +: VPN_IDX_WIDTH];
    case (level_q)
      2'd2:    vpn_idx = vpn_q[2*VPN_IDX_WIDTH +: VPN_IDX_WIDTH];
      2'd1:    vpn_idx = vpn_q[VPN_IDX_WIDTH +: VPN_IDX_WIDTH];
      default: vpn_idx = vpn_q[0 +: VPN_IDX_WIDTH];
    endcase
  end

  // Address depends only on walk registers, so it holds steady while REQ is stalled
  assign addr_full       = {a_ppn_q, vpn_idx, {PTE_SIZE_LOG2{1'b0}}};
  assign mem_req_paddr_o = PADDR_WIDTH'(addr_full);

  assign ptw_req_rdy_o           = (state_q == PTW_IDLE);
  assign mem_req_vld_o           = (state_q == PTW_REQ);
  assign ptw_resp_vld_o          = (state_q == PTW_RESP);
  assign ptw_resp_trans_id_o     = trans_id_q;
  assign ptw_resp_asid_o         = asid_q;
  assign ptw_resp_vpn_o          = vpn_q;
  assign ptw_resp_access_type_o  = acc_q;
  assign ptw_resp_pte_o          = pte_q;
  assign ptw_resp_level_o        = res_level_q;
  assign ptw_resp_page_fault_o   = pf_q;
  assign ptw_resp_access_fault_o = af_q;

  // Walk FSM: next state and register updates
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    a_ppn_d     = a_ppn_q;
    trans_id_d  = trans_id_q;
    asid_d      = asid_q;
    vpn_d       = vpn_q;
    acc_d       = acc_q;
    pte_d       = pte_q;
    res_level_d = res_level_q;
    pf_d        = pf_q;
    af_d        = af_q;
    case (state_q)
      PTW_IDLE: begin
        if (ptw_req_vld_i) begin
          trans_id_d = ptw_req_trans_id_i;
          asid_d     = ptw_req_asid_i;
          vpn_d      = ptw_req_vpn_i;
          acc_d      = ptw_req_access_type_i;
          a_ppn_d    = satp_ppn_i;
          level_d    = 2'd2;
          state_d    = PTW_REQ;
        end
      end
      PTW_REQ: begin
        if (mem_req_rdy_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (mem_resp_vld_i) begin
          if (chk_af || chk_pf || chk_leaf) begin
            // Terminal: faults report a zero PTE at the level where they hit
            pte_d       = (chk_af || chk_pf) ? 64'd0 : mem_resp_pte_i;
            res_level_d = level_q;
            pf_d        = chk_pf;
            af_d        = chk_af;
            state_d     = PTW_RESP;
          end else begin
            a_ppn_d = PPN_WIDTH'(chk_next_ppn);
            level_d = level_q - 2'd1;
            state_d = PTW_REQ;
          end
        end
      end
      PTW_RESP: begin
        state_d = PTW_IDLE;
      end
      default: state_d = PTW_IDLE;
    endcase
  end

  // State and walk registers; reset drops any walk in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= PTW_IDLE;
      level_q     <= 2'd2;
      a_ppn_q     <= '0;
      trans_id_q  <= '0;
      asid_q      <= '0;
      vpn_q       <= '0;
      acc_q       <= '0;
      pte_q       <= '0;
      res_level_q <= '0;
      pf_q        <= 1'b0;
      af_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      a_ppn_q     <= a_ppn_d;
      trans_id_q  <= trans_id_d;
      asid_q      <= asid_d;
      vpn_q       <= vpn_d;
      acc_q       <= acc_d;
      pte_q       <= pte_d;
      res_level_q <= res_level_d;
      pf_q        <= pf_d;
      af_q        <= af_d;
    end
  end

endmodule

// File: tb/tb_rvh_mmu_ptw.sv
// Bench for rvh_mmu_ptw: table of walks against a scripted PTE memory, scoreboard of expected responses.
module tb_rvh_mmu_ptw;

  logic        clk = 1'b0;
  logic        rstn;
  logic [43:0] satp_ppn_i;
  logic        ptw_req_vld_i, ptw_req_rdy_o;
  logic [2:0]  ptw_req_trans_id_i;
  logic [15:0] ptw_req_asid_i;
  logic [26:0] ptw_req_vpn_i;
  logic [1:0]  ptw_req_access_type_i;
  logic        mem_req_vld_o, mem_req_rdy_i;
  logic [55:0] mem_req_paddr_o;
  logic        mem_resp_vld_i, mem_resp_err_i;
  logic [63:0] mem_resp_pte_i;
  logic        ptw_resp_vld_o;
  logic [2:0]  ptw_resp_trans_id_o;
  logic [15:0] ptw_resp_asid_o;
  logic [26:0] ptw_resp_vpn_o;
  logic [1:0]  ptw_resp_access_type_o;
  logic [63:0] ptw_resp_pte_o;
  logic [1:0]  ptw_resp_level_o;
  logic        ptw_resp_page_fault_o, ptw_resp_access_fault_o;

  rvh_mmu_ptw dut (
    .clk(clk), .rstn(rstn), .satp_ppn_i(satp_ppn_i),
    .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_rdy_o(ptw_req_rdy_o),
    .ptw_req_trans_id_i(ptw_req_trans_id_i), .ptw_req_asid_i(ptw_req_asid_i),
    .ptw_req_vpn_i(ptw_req_vpn_i), .ptw_req_access_type_i(ptw_req_access_type_i),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_paddr_o(mem_req_paddr_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_resp_vld_i(mem_resp_vld_i), .mem_resp_pte_i(mem_resp_pte_i), .mem_resp_err_i(mem_resp_err_i),
    .ptw_resp_vld_o(ptw_resp_vld_o), .ptw_resp_trans_id_o(ptw_resp_trans_id_o),
    .ptw_resp_asid_o(ptw_resp_asid_o), .ptw_resp_vpn_o(ptw_resp_vpn_o),
    .ptw_resp_access_type_o(ptw_resp_access_type_o), .ptw_resp_pte_o(ptw_resp_pte_o),
    .ptw_resp_level_o(ptw_resp_level_o), .ptw_resp_page_fault_o(ptw_resp_page_fault_o),
    .ptw_resp_access_fault_o(ptw_resp_access_fault_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [43:0]       satp;
    logic [26:0]       vpn;
    logic [2:0][63:0]  pte;    // PTE returned for the 1st/2nd/3rd read
    logic [2:0][55:0]  addr;   // expected address of the 1st/2nd/3rd read
    int                err_idx; // which read returns a bus error (-1: none)
    int                stall;   // cycles mem_req_rdy_i held low on the first read
    logic [63:0]       exp_pte;
    logic [1:0]        exp_level;
    logic              exp_pf, exp_af;
    int                nreq, lat;
  } vec_t;

  typedef struct {
    logic [2:0]  trans_id;
    logic [15:0] asid;
    logic [26:0] vpn;
    logic [1:0]  acc;
    logic [63:0] pte;
    logic [1:0]  level;
    logic        pf, af;
    int          acc_cyc, lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [43:0] satp, input logic [26:0] vpn,
                              input logic [63:0] p0, p1, p2, input logic [55:0] a0, a1, a2,
                              input int err_idx, stall, input logic [63:0] exp_pte,
                              input logic [1:0] exp_level, input logic pf, af, input int nreq, lat);
    vec_t v;
    v.satp = satp; v.vpn = vpn;
    v.pte[0] = p0; v.pte[1] = p1; v.pte[2] = p2;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.err_idx = err_idx; v.stall = stall;
    v.exp_pte = exp_pte; v.exp_level = exp_level; v.exp_pf = pf; v.exp_af = af;
    v.nreq = nreq; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard side: every response must match the oldest outstanding expectation
  task automatic mon();
    exp_t e;
    if (ptw_resp_vld_o !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_resp: got response trans_id %0d, expected none (cycle %0d)",
                 ptw_resp_trans_id_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_trans_id", 64'(ptw_resp_trans_id_o), 64'(e.trans_id));
        chk("resp_asid", 64'(ptw_resp_asid_o), 64'(e.asid));
        chk("resp_vpn", 64'(ptw_resp_vpn_o), 64'(e.vpn));
        chk("resp_access_type", 64'(ptw_resp_access_type_o), 64'(e.acc));
        chk("resp_pte", ptw_resp_pte_o, e.pte);
        chk("resp_level", 64'(ptw_resp_level_o), 64'(e.level));
        chk("resp_page_fault", 64'(ptw_resp_page_fault_o), 64'(e.pf));
        chk("resp_access_fault", 64'(ptw_resp_access_fault_o), 64'(e.af));
        chk("resp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_rdy"}, 64'(ptw_req_rdy_o), 64'd1);
    chk({tag, "_mem_req_vld"}, 64'(mem_req_vld_o), 64'd0);
    chk({tag, "_mem_paddr"}, 64'(mem_req_paddr_o), 64'd0);
    chk({tag, "_resp_vld"}, 64'(ptw_resp_vld_o), 64'd0);
    chk({tag, "_resp_trans_id"}, 64'(ptw_resp_trans_id_o), 64'd0);
    chk({tag, "_resp_asid"}, 64'(ptw_resp_asid_o), 64'd0);
    chk({tag, "_resp_vpn"}, 64'(ptw_resp_vpn_o), 64'd0);
    chk({tag, "_resp_pte"}, ptw_resp_pte_o, 64'd0);
    chk({tag, "_resp_level"}, 64'(ptw_resp_level_o), 64'd0);
    chk({tag, "_resp_faults"}, 64'({ptw_resp_page_fault_o, ptw_resp_access_fault_o}), 64'd0);
  endtask

  // Drive one miss and act as a PTE memory until its response retires from the scoreboard
  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   k, stall;
    logic issue;
    tick();
    chk("req_rdy_idle", 64'(ptw_req_rdy_o), 64'd1);
    ptw_req_vld_i         = 1'b1;
    ptw_req_trans_id_i    = 3'(id);
    ptw_req_asid_i        = 16'hA000 + 16'(id);
    ptw_req_vpn_i         = v.vpn;
    ptw_req_access_type_i = 2'(id);
    satp_ppn_i            = v.satp;
    mem_req_rdy_i         = 1'b1;
    e.trans_id = 3'(id); e.asid = 16'hA000 + 16'(id); e.vpn = v.vpn; e.acc = 2'(id);
    e.pte = v.exp_pte; e.level = v.exp_level; e.pf = v.exp_pf; e.af = v.exp_af;
    e.acc_cyc = cyc; e.lat = v.lat;
    sb.push_back(e);
    k = 0; stall = v.stall; issue = 1'b0;
    for (int c = 0; c < 80 && sb.size() != 0; c++) begin
      tick();
      if (c == 0) begin
        ptw_req_vld_i = 1'b0;
        satp_ppn_i    = '1;  // must already be sampled
      end
      mem_resp_vld_i = 1'b0; mem_resp_err_i = 1'b0; mem_resp_pte_i = '0;
      if (issue) begin
        mem_resp_vld_i = 1'b1;
        mem_resp_pte_i = v.pte[k-1];
        mem_resp_err_i = (v.err_idx == k - 1);
        issue = 1'b0;
      end
      if (mem_req_vld_o === 1'b1) begin
        if (k < 3) chk("mem_paddr", 64'(mem_req_paddr_o), 64'(v.addr[k]));
        if (stall > 0) begin
          stall--;
          mem_req_rdy_i = 1'b0;
          chk("req_rdy_busy", 64'(ptw_req_rdy_o), 64'd0);
          ptw_req_vld_i      = 1'b1;  // competing miss must be refused
          ptw_req_trans_id_i = ~3'(id);
        end else begin
          mem_req_rdy_i = 1'b1;
          ptw_req_vld_i = 1'b0;
          k++;
          issue = 1'b1;
        end
      end
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_vec%0d: got no response, expected one", id);
      sb.delete();
    end
    chk("mem_req_count", 64'(k), 64'(v.nreq));
    mem_resp_vld_i = 1'b0; mem_resp_err_i = 1'b0;
  endtask

  initial begin
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h20000801, 64'h48D14CF,
                      56'h80000008, 56'h80001008, 56'h80002008, -1, 0, 64'h48D14CF, 2'd0, 0, 0, 3, 7));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h480004CF, 64'h0,
                      56'h80000008, 56'h80001008, 56'h0, -1, 0, 64'h0, 2'd1, 1, 0, 2, 5));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h0, 64'h0, 64'h0,
                      56'h80000008, 56'h0, 56'h0, -1, 0, 64'h0, 2'd2, 1, 0, 1, 3));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h0, 64'h0,
                      56'h80000008, 56'h0, 56'h0, 0, 0, 64'h0, 2'd2, 0, 1, 1, 3));
    vecs.push_back(mk(44'h12345, 27'h7FC0000, 64'h100000CF, 64'h0, 64'h0,
                      56'h12345FF8, 56'h0, 56'h0, -1, 0, 64'h100000CF, 2'd2, 0, 0, 1, 3));
    vecs.push_back(mk(44'h12345, 27'h7FC0000, 64'h100004CF, 64'h0, 64'h0,
                      56'h12345FF8, 56'h0, 56'h0, -1, 0, 64'h0, 2'd2, 1, 0, 1, 3));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h5, 64'h0,
                      56'h80000008, 56'h80001008, 56'h0, -1, 0, 64'h0, 2'd1, 1, 0, 2, 5));
    vecs.push_back(mk(44'h80000, 27'h00D57FF, 64'h20000401, 64'h20000801, 64'h20000C01,
                      56'h80000018, 56'h80001558, 56'h80002FF8, -1, 0, 64'h0, 2'd0, 1, 0, 3, 7));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h20000801, 64'h48D14CF,
                      56'h80000008, 56'h80001008, 56'h80002008, -1, 5, 64'h48D14CF, 2'd0, 0, 0, 3, 12));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h20000801, 64'h48D14CF,
                      56'h80000008, 56'h80001008, 56'h80002008, 2, 0, 64'h0, 2'd0, 0, 1, 3, 7));
    vecs.push_back(mk(44'h80000, 27'h0040201, 64'h20000401, 64'h48000009, 64'h0,
                      56'h80000008, 56'h80001008, 56'h0, -1, 0, 64'h48000009, 2'd1, 0, 0, 2, 5));

    rstn = 1'b0;
    satp_ppn_i = '0; ptw_req_vld_i = 1'b0; ptw_req_trans_id_i = '0; ptw_req_asid_i = '0;
    ptw_req_vpn_i = '0; ptw_req_access_type_i = '0; mem_req_rdy_i = 1'b1;
    mem_resp_vld_i = 1'b0; mem_resp_pte_i = '0; mem_resp_err_i = 1'b0;
    tick(); tick();
    chk_reset_outputs("por");
    rstn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Spurious read data while idle must be ignored
    tick();
    mem_resp_vld_i = 1'b1; mem_resp_pte_i = 64'h48D14CF;
    tick();
    mem_resp_vld_i = 1'b0;
    chk("idle_spurious_rdy", 64'(ptw_req_rdy_o), 64'd1);
    chk("idle_spurious_memvld", 64'(mem_req_vld_o), 64'd0);
    tick();
    chk("idle_spurious_rdy2", 64'(ptw_req_rdy_o), 64'd1);

    // Start a walk that will be abandoned: nothing goes on the scoreboard
    ptw_req_vld_i = 1'b1; ptw_req_trans_id_i = 3'd5; ptw_req_asid_i = 16'h5555;
    ptw_req_vpn_i = 27'h0040201; ptw_req_access_type_i = 2'd1; satp_ppn_i = 44'h80000;
    mem_req_rdy_i = 1'b0;
    tick();
    ptw_req_vld_i = 1'b0;
    chk("req_spurious_memvld", 64'(mem_req_vld_o), 64'd1);
    chk("req_spurious_paddr", 64'(mem_req_paddr_o), 64'h80000008);
    mem_resp_vld_i = 1'b1; mem_resp_pte_i = 64'h48D14CF;  // arrives while still in REQ
    tick();
    mem_resp_vld_i = 1'b0;
    chk("req_after_spurious_memvld", 64'(mem_req_vld_o), 64'd1);
    chk("req_after_spurious_paddr", 64'(mem_req_paddr_o), 64'h80000008);
    mem_req_rdy_i = 1'b1;
    tick();
    chk("wait_memvld", 64'(mem_req_vld_o), 64'd0);
    chk("wait_rdy", 64'(ptw_req_rdy_o), 64'd0);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midwalk");
    tick(); tick();
    rstn = 1'b1;
    mem_resp_vld_i = 1'b1; mem_resp_pte_i = 64'h48D14CF;  // late data for the dead walk
    tick();
    mem_resp_vld_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_reset_rdy", 64'(ptw_req_rdy_o), 64'd1);
    chk("post_reset_resp_vld", 64'(ptw_resp_vld_o), 64'd0);

    // Walker resumes normally after the reset
    run_vec(vecs[0], 6);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
